// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow signal in clock cycles, with lock and loss detection
module clk_period_meter #(
    parameter int          CNT_W       = 32,
    parameter int unsigned TIMEOUT     = 200_000_000,
    parameter int          SYNC_STAGES = 2,
    parameter int          TOL         = 2
) (
    input  logic             i_clkin,
    input  logic             i_rst_n,
    input  logic             i_sig_in,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high_time,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_timeout
);
    typedef enum logic [1:0] {S_IDLE, S_MEAS, S_LOST} state_t;
    localparam logic [CNT_W-1:0] LP_TO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   LP_TOL = (CNT_W+1)'(TOL);
    state_t r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic r_prev, r_valid, r_locked, r_timeout;
    logic [CNT_W-1:0] r_cnt, r_hi_lat, r_prev_period, r_period, r_high_time;
    logic w_sig_s, w_rise, w_fall, w_cnt_to, w_close;
    logic w_meas_rise, w_hi_ld, w_lose, w_regain;
    logic [CNT_W:0] w_diff;
    assign w_sig_s  = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_sig_s & ~r_prev;
    assign w_fall   = ~w_sig_s & r_prev;
    assign w_cnt_to = r_cnt == LP_TO;
    // Unsigned distance between the new and previous period, one bit wider so it never wraps
    assign w_diff   = (r_cnt >= r_prev_period) ? {1'b0, r_cnt} - {1'b0, r_prev_period}
                                               : {1'b0, r_prev_period} - {1'b0, r_cnt};
    assign w_close  = w_diff <= LP_TOL;
    // Synchroniser chain and one-cycle delayed copy for edge detection
    always_ff @(posedge i_clkin or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig_in};
            r_prev <= w_sig_s;
        end
    end
    // Cycles since the last rise; restarts at 1 on a rise and saturates
    always_ff @(posedge i_clkin or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else
            r_cnt <= w_rise ? CNT_W'(1) : (&r_cnt ? r_cnt : r_cnt + CNT_W'(1));
    end
    // State register
    always_ff @(posedge i_clkin or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end
    // Next state and datapath strobes; a rise always wins over a simultaneous timeout
    always_comb begin
        w_state_nxt = r_state;
        w_meas_rise = 1'b0;
        w_hi_ld     = 1'b0;
        w_lose      = 1'b0;
        w_regain    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = S_MEAS;
                end else if (w_cnt_to) begin
                    w_state_nxt = S_LOST;
                    w_lose      = 1'b1;
                end
            end
            S_MEAS: begin
                if (w_rise) begin
                    w_meas_rise = 1'b1;
                end else if (w_cnt_to) begin
                    w_state_nxt = S_LOST;
                    w_lose      = 1'b1;
                end else if (w_fall) begin
                    w_hi_ld     = 1'b1;
                end
            end
            S_LOST: begin
                if (w_rise) begin
                    w_state_nxt = S_MEAS;
                    w_regain    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
    // Measurement results, lock and loss flags
    always_ff @(posedge i_clkin or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi_lat      <= '0;
            r_prev_period <= '0;
            r_period      <= '0;
            r_high_time   <= '0;
            r_valid       <= 1'b0;
            r_locked      <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_valid <= w_meas_rise;
            if (w_lose) begin
                r_hi_lat      <= '0;
                r_prev_period <= '0;
                r_period      <= '0;
                r_high_time   <= '0;
                r_locked      <= 1'b0;
                r_timeout     <= 1'b1;
            end else begin
                if (w_regain)
                    r_timeout <= 1'b0;
                if (w_hi_ld)
                    r_hi_lat <= r_cnt;
                if (w_meas_rise) begin
                    r_period      <= r_cnt;
                    r_high_time   <= r_hi_lat;
                    r_prev_period <= r_cnt;
                    r_locked      <= w_close && (r_prev_period != '0);
                end
            end
        end
    end
    assign o_period    = r_period;
    assign o_high_time = r_high_time;
    assign o_valid     = r_valid;
    assign o_locked    = r_locked;
    assign o_timeout   = r_timeout;
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: table-driven scoreboard bench for clk_period_meter
module tb_clk_period_meter;
    localparam int CNT_W = 16;
    typedef struct { int hi; int lo; bit v; int per; int ht; bit lk; } rec_t;
    typedef struct { int per; int ht; bit lk; } exp_t;
    logic clk = 1'b0, rst_n = 1'b0, sig = 1'b0;
    logic [CNT_W-1:0] o_period, o_high_time;
    logic o_valid, o_locked, o_timeout;
    int n_vec = 0, n_err = 0, cyc = 0, last_v = 0;
    exp_t sb[$];
    exp_t e_mon;
    rec_t tab[19];

    clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(50), .SYNC_STAGES(2), .TOL(2)) dut (
        .i_clkin(clk), .i_rst_n(rst_n), .i_sig_in(sig),
        .o_period(o_period), .o_high_time(o_high_time),
        .o_valid(o_valid), .o_locked(o_locked), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, longint act, longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic rec_t mk(int hi, int lo, bit v, int per, int ht, bit lk);
        rec_t r;
        r.hi = hi; r.lo = lo; r.v = v; r.per = per; r.ht = ht; r.lk = lk;
        return r;
    endfunction

    task automatic drive(rec_t r);
        exp_t e;
        if (r.v) begin
            e.per = r.per; e.ht = r.ht; e.lk = r.lk;
            sb.push_back(e);
        end
        sig = 1'b1;
        repeat (r.hi) @(negedge clk);
        sig = 1'b0;
        repeat (r.lo) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (o_valid) begin
            last_v = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e_mon = sb.pop_front();
                chk("period", o_period, e_mon.per);
                chk("high_time", o_high_time, e_mon.ht);
                chk("locked", o_locked, e_mon.lk);
            end
        end
    end

    initial begin
        tab[0]  = mk(5, 5, 0, 0, 0, 0);
        tab[1]  = mk(5, 5, 1, 10, 5, 0);
        tab[2]  = mk(5, 5, 1, 10, 5, 1);
        tab[3]  = mk(3, 7, 1, 10, 5, 1);
        tab[4]  = mk(3, 7, 1, 10, 3, 1);
        tab[5]  = mk(10, 10, 1, 10, 3, 1);
        tab[6]  = mk(10, 10, 1, 20, 10, 0);
        tab[7]  = mk(6, 6, 1, 20, 10, 1);
        tab[8]  = mk(6, 6, 1, 12, 6, 0);
        tab[9]  = mk(5, 5, 1, 12, 6, 1);
        tab[10] = mk(5, 5, 1, 10, 5, 1);
        tab[11] = mk(4, 5, 1, 10, 5, 1);
        tab[12] = mk(5, 5, 1, 9, 4, 1);
        tab[13] = mk(6, 7, 1, 10, 5, 1);
        tab[14] = mk(5, 5, 1, 13, 6, 0);
        tab[15] = mk(5, 5, 1, 10, 5, 0);
        tab[16] = mk(5, 5, 1, 10, 5, 1);
        tab[17] = mk(6, 6, 1, 10, 5, 1);
        tab[18] = mk(5, 5, 1, 12, 6, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sig = ~sig;
            chk("rst_flags", {o_valid, o_locked, o_timeout}, 0);
            chk("rst_period", o_period, 0);
            chk("rst_high", o_high_time, 0);
        end
        sig = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 19; i++) drive(tab[i]);
        begin
            int k;
            for (k = 0; k < 200 && !o_timeout; k++) @(negedge clk);
        end
        chk("timeout_seen", o_timeout, 1);
        chk("timeout_delay", cyc - last_v, 50);
        chk("lost_locked", o_locked, 0);
        chk("lost_period", o_period, 0);
        chk("lost_high", o_high_time, 0);
        chk("sb_drained", sb.size(), 0);
        drive(mk(5, 5, 0, 0, 0, 0));
        chk("timeout_cleared", o_timeout, 0);
        drive(mk(5, 5, 1, 10, 5, 0));
        drive(mk(5, 5, 1, 10, 5, 1));
        drive(mk(5, 3, 1, 10, 5, 1));
        chk("locked_before_rst", o_locked, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_flags", {o_valid, o_locked, o_timeout}, 0);
        chk("async_rst_period", o_period, 0);
        chk("async_rst_high", o_high_time, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        drive(mk(5, 5, 0, 0, 0, 0));
        drive(mk(5, 5, 1, 10, 5, 0));
        drive(mk(5, 5, 1, 10, 5, 1));
        repeat (5) @(negedge clk);
        chk("sb_final", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
